pmem_responder: RTL

Line-granular physical-memory responder that terminates the 256-bit `pmem_*` request interface driven by the cache hierarchy's last level. It accepts one line read or line write at a time, waits a programmable number of cycles, then completes it with a single-cycle `pmem_resp` pulse, returning read data from an internal line array. It serves as the memory-side endpoint of the cache group in synthesizable test systems and FPGA builds.

---
 rtl/pmem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pmem_responder
// Description : Line-granular physical-memory responder for the 256-bit
//               pmem_* interface. Accepts one line read or write at a time,
//               waits LATENCY cycles, then completes it with a one-cycle
//               pmem_resp pulse. Reads return data from an internal array.
// Revision    : 1.0 - initial release
//
// Parameters  : LINE_ADDR_BITS - line-index width (2^LINE_ADDR_BITS lines)
//               LATENCY        - acceptance-to-response cycles, 1..255
// Ports       : clk, rst       - clock, synchronous active-high reset
//               pmem_read/write, pmem_address, pmem_wdata - request side
//               pmem_resp, pmem_rdata - completion pulse and read line
//               req_error      - sticky, set by simultaneous read+write
//               read_count, write_count - completed-op counters
// Macro       : PMEM_STATS_EN  - builds the completion counters; when
//               undefined read_count/write_count are tied to zero.
// ============================================================================
module pmem_responder #(
  parameter int LINE_ADDR_BITS = 8,
  parameter int LATENCY        = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [255:0] pmem_rdata,
  output logic         req_error,
  output logic [31:0]  read_count,
  output logic [31:0]  write_count
);

  localparam int         c_lines  = 1 << LINE_ADDR_BITS;
  localparam logic [7:0] c_lat_m1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESP    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [7:0]                r_cnt;
  logic [LINE_ADDR_BITS-1:0] r_idx;
  logic                      r_is_write;
  logic [255:0]              r_wdata;
  logic [255:0]              r_rdata;
  logic                      r_resp;
  logic                      r_err;
  logic [255:0]              r_mem [c_lines];

  logic                      w_accept;
  logic                      w_enter_resp;
  logic                      w_op_write;
  logic [LINE_ADDR_BITS-1:0] w_op_idx;
  logic [255:0]              w_op_wdata;
  logic                      w_unused_addr;

  // Offset bits and bits above the line index never affect behaviour.
  assign w_unused_addr = ^{pmem_address[31:LINE_ADDR_BITS+5], pmem_address[4:0]};

  assign w_accept     = (r_state == S_IDLE) && (pmem_read || pmem_write);
  assign w_enter_resp = (w_next == S_RESP);

  // With LATENCY=1 RESP is entered on the acceptance edge itself, before the
  // request has been latched, so the operation is taken straight from the
  // inputs while in IDLE and from the latched copy otherwise.
  assign w_op_write = (r_state == S_IDLE) ? pmem_write : r_is_write;
  assign w_op_idx   = (r_state == S_IDLE) ? pmem_address[LINE_ADDR_BITS+4:5] : r_idx;
  assign w_op_wdata = (r_state == S_IDLE) ? pmem_wdata : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (pmem_read || pmem_write) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:    if (r_cnt == 8'd1) w_next = S_RESP;
      S_RESP:    w_next = S_RECOVER;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 8'd0;
      r_idx      <= '0;
      r_is_write <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_resp     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_resp <= w_enter_resp;
      if (w_accept) begin
        r_cnt      <= c_lat_m1;
        r_idx      <= pmem_address[LINE_ADDR_BITS+4:5];
        r_is_write <= pmem_write;
        r_wdata    <= pmem_wdata;
        if (pmem_read && pmem_write) r_err <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_enter_resp && !w_op_write) r_rdata <= r_mem[w_op_idx];
    end
  end

  // The array is not reset; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_op_write) r_mem[w_op_idx] <= w_op_wdata;
  end

  assign pmem_resp  = r_resp;
  assign pmem_rdata = r_rdata;
  assign req_error  = r_err;

`ifdef PMEM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= 32'd0;
      r_wr_cnt <= 32'd0;
    end else if (w_enter_resp) begin
      if (w_op_write) r_wr_cnt <= r_wr_cnt + 32'd1;
      else            r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign read_count  = r_rd_cnt;
  assign write_count = r_wr_cnt;
`else
  assign read_count  = 32'd0;
  assign write_count = 32'd0;
`endif

endmodule
`default_nettype wire
